// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Optional line lock is enabled with UART_ARB_LINE_LOCK_EN.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0]  LF_BYTE = 8'h0A;
  localparam int unsigned UART_DW = 32;

  // Next index after v, wrapping back to 0 at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible requester at or after i_ptr, wrapping.
// Used by uart_tx_arbiter; i_mask restricts the candidates when UART_ARB_LINE_LOCK_EN locks a line.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [NREQ-1:0] i_mask,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_found_c,
  output logic [IDW-1:0]  o_idx_c
);

  localparam int unsigned NPAD = 1 << IDW;

  logic [NPAD-1:0] w_elig;
  logic [IDW-1:0]  w_cand;

  assign w_elig = NPAD'(i_valid & i_mask);

  // Walk NREQ candidates starting at i_ptr; the first hit wins.
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDW'((32'(i_ptr) + k >= NREQ) ? (32'(i_ptr) + k - NREQ) : (32'(i_ptr) + k));
      if (!o_found_c && w_elig[w_cand]) begin
        o_found_c = 1'b1;
        o_idx_c   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit data register among NREQ byte sources.
// Define UART_ARB_LINE_LOCK_EN to keep a granted source locked until it sends LF.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic                 bus_clk,
  input  logic                 bus_reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 uart_dat_we,
  output logic [UART_DW-1:0]   uart_dat_di,
  input  logic                 uart_dat_ack,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [NREQ-1:0]  r_ready;
  logic             r_we;
  logic [7:0]       r_di;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_ptr;
  logic             r_busy;

  logic [NREQ-1:0]  w_ready_nxt;
  logic             w_we_nxt;
  logic [7:0]       w_di_nxt;
  logic [IDW-1:0]   w_grant_nxt;
  logic [IDW-1:0]   w_ptr_nxt;

  logic [NREQ-1:0]  w_mask;
  logic             w_found;
  logic [IDW-1:0]   w_idx;
  logic [7:0]       w_sel_byte;

`ifdef UART_ARB_LINE_LOCK_EN
  logic             r_lock;
  logic             w_lock_nxt;

  // While locked only the owner of the open line may be picked.
  assign w_mask = r_lock ? (NREQ'(1) << r_grant) : '1;
`else
  assign w_mask = '1;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_valid   (req_valid),
    .i_mask    (w_mask),
    .i_ptr     (r_ptr),
    .o_found_c (w_found),
    .o_idx_c   (w_idx)
  );

  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == w_idx) w_sel_byte = req_data[i*8 +: 8];
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)      w_state_nxt = SEND;
      SEND:    if (uart_dat_ack) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; everything holds unless the FSM acts.
  always_comb begin
    w_ready_nxt = '0;
    w_we_nxt    = r_we;
    w_di_nxt    = r_di;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
`ifdef UART_ARB_LINE_LOCK_EN
    w_lock_nxt  = r_lock;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_ready_nxt = NREQ'(1) << w_idx;
          w_we_nxt    = 1'b1;
          w_di_nxt    = w_sel_byte;
          w_grant_nxt = w_idx;
`ifdef UART_ARB_LINE_LOCK_EN
          w_lock_nxt  = (w_sel_byte != LF_BYTE);
`endif
        end
      end
      SEND: begin
        if (uart_dat_ack) begin
          w_we_nxt  = 1'b0;
          w_ptr_nxt = IDW'(wrap_inc(32'(r_grant), NREQ));
        end
      end
      default: begin
        w_we_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      r_ready <= '0;
      r_we    <= 1'b0;
      r_di    <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
`ifdef UART_ARB_LINE_LOCK_EN
      r_lock  <= 1'b0;
`endif
    end else begin
      r_ready <= w_ready_nxt;
      r_we    <= w_we_nxt;
      r_di    <= w_di_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
`ifdef UART_ARB_LINE_LOCK_EN
      r_lock  <= w_lock_nxt;
`endif
    end
  end

  assign req_ready   = r_ready;
  assign uart_dat_we = r_we;
  assign uart_dat_di = UART_DW'(r_di);
  assign grant_id    = r_grant;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=3): directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 3;

  logic                 bus_clk;
  logic                 bus_reset;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 uart_dat_we;
  logic [31:0]          uart_dat_di;
  logic                 uart_dat_ack;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .bus_clk      (bus_clk),
    .bus_reset    (bus_reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_dat_we  (uart_dat_we),
    .uart_dat_di  (uart_dat_di),
    .uart_dat_ack (uart_dat_ack),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  // Reference model state
  bit              m_busy;
  bit              m_lock;
  bit              new_grant;
  int              m_grant;
  int              m_ptr;
  logic [7:0]      m_byte;
  logic [NREQ-1:0] m_ready;

  // Requester byte streams
  logic [7:0] fifo [NREQ][16];
  int         rd   [NREQ];
  int         cnt  [NREQ];
  logic [7:0] idle_byte [NREQ];

  bit          rand_mode;
  int          ack_delay;
  int          ack_cnt;
  int          we_cycles;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    if (cnt[i] < 16) begin
      fifo[i][(rd[i] + cnt[i]) % 16] = b;
      cnt[i]++;
    end
  endtask

  task automatic expect_byte(input int g, input logic [7:0] b);
    exp_q.push_back({8'(g), b});
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bit drop;
      if (rand_mode && cnt[i] < 4 && $urandom_range(0, 3) == 0)
        push(i, ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
      drop = rand_mode && ($urandom_range(0, 7) == 0);
      req_valid[i]      = (cnt[i] > 0) && !drop;
      req_data[i*8 +: 8] = (cnt[i] > 0) ? fifo[i][rd[i]] : idle_byte[i];
    end
  endtask

  task automatic drive_ack();
    if (new_grant) ack_cnt = rand_mode ? int'($urandom_range(0, 3)) : ack_delay;
    if (m_busy) begin
      uart_dat_ack = (ack_cnt == 0);
      if (ack_cnt > 0) ack_cnt--;
    end else begin
      uart_dat_ack = rand_mode && ($urandom_range(0, 3) == 0);
    end
  endtask

  // Applies the arbitration rules to the inputs present at this clock edge.
  task automatic model_update();
    new_grant = 1'b0;
    m_ready   = '0;
    if (bus_reset) begin
      m_busy = 1'b0; m_lock = 1'b0; m_grant = 0; m_ptr = 0; m_byte = 8'h00;
    end else if (!m_busy) begin
      int w;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[idx] && (!m_lock || idx == m_grant)) w = idx;
      end
      if (w >= 0) begin
        m_busy     = 1'b1;
        m_grant    = w;
        m_byte     = fifo[w][rd[w]];
        rd[w]      = (rd[w] + 1) % 16;
        cnt[w]--;
        m_ready[w] = 1'b1;
        new_grant  = 1'b1;
`ifdef UART_ARB_LINE_LOCK_EN
        m_lock     = (m_byte != 8'h0A);
`endif
      end
    end else if (uart_dat_ack) begin
      m_busy = 1'b0;
      m_ptr  = (m_grant + 1) % NREQ;
    end
  endtask

  task automatic step();
    @(negedge bus_clk);
    check("we",    32'(uart_dat_we), 32'(m_busy));
    check("di",    uart_dat_di,      {24'd0, m_byte});
    check("ready", 32'(req_ready),   32'(m_ready));
    check("grant", 32'(grant_id),    32'(m_grant));
    check("busy",  32'(busy),        32'(m_busy));
    if (uart_dat_we === 1'b1) we_cycles++;
    if (uart_dat_we === 1'b1 && uart_dat_ack && !bus_reset)
      got_q.push_back({8'(grant_id), uart_dat_di[7:0]});
    @(posedge bus_clk);
    model_update();
    #1;
    drive_reqs();
    drive_ack();
  endtask

  function automatic bit is_done();
    bit d;
    d = !m_busy;
    for (int i = 0; i < NREQ; i++) if (cnt[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input int max_cycles, input string tag);
    int c;
    c = 0;
    while (!is_done() && c < max_cycles) begin
      step();
      c++;
    end
    check({tag, "_drain"}, 32'(is_done()), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus_reset = 1'b1;
    step();
    step();
    bus_reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    bus_reset = 1'b1; req_valid = '0; req_data = '0; uart_dat_ack = 1'b0;
    m_busy = 1'b0; m_lock = 1'b0; new_grant = 1'b0; m_grant = 0; m_ptr = 0;
    m_byte = 8'h00; m_ready = '0;
    rand_mode = 1'b0; ack_delay = 2; ack_cnt = 0; we_cycles = 0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = 0; cnt[i] = 0; idle_byte[i] = 8'(8'hE0 + i);
    end

    // Reset state and idle stability
    repeat (3) step();
    bus_reset = 1'b0;
    repeat (4) step();

    // Single request, ack five cycles into the write
    do_reset();
    ack_delay = 4; we_cycles = 0;
    push(0, 8'h41); drive_reqs();
    run_until_idle(40, "t1");
    check("t1_we_cycles", 32'(we_cycles), 32'd5);
    expect_byte(0, 8'h41);
    check_seq("t1");

    // Contention between two continuous sources
    do_reset();
    ack_delay = 2;
`ifdef UART_ARB_LINE_LOCK_EN
    for (int n = 0; n < 2; n++) begin
      push(0, 8'h30); push(0, 8'h0A); push(1, 8'h61); push(1, 8'h0A);
    end
    for (int n = 0; n < 2; n++) begin
      expect_byte(0, 8'h30); expect_byte(0, 8'h0A); expect_byte(1, 8'h61); expect_byte(1, 8'h0A);
    end
`else
    for (int n = 0; n < 4; n++) begin
      push(0, 8'h30); push(1, 8'h61);
      expect_byte(0, 8'h30); expect_byte(1, 8'h61);
    end
`endif
    drive_reqs();
    run_until_idle(100, "t2");
    check_seq("t2");

    // Pointer wrap: move pointer to 2, then only requesters 2 and 0 compete
    do_reset();
    push(1, 8'h0A); drive_reqs();
    run_until_idle(30, "t3a");
    push(0, 8'h0A); push(2, 8'h0A); push(2, 8'h0A); drive_reqs();
    run_until_idle(60, "t3b");
    expect_byte(1, 8'h0A); expect_byte(2, 8'h0A); expect_byte(0, 8'h0A); expect_byte(2, 8'h0A);
    check_seq("t3");

    // Source changes its data after being granted
    do_reset();
    idle_byte[0] = 8'hAA;
    push(0, 8'h55); drive_reqs();
    run_until_idle(30, "t4");
    expect_byte(0, 8'h55);
    check_seq("t4");
    idle_byte[0] = 8'hE0;

    // Reset while waiting for ack; the other pending request is served afterwards
    do_reset();
    ack_delay = 100;
    push(0, 8'h11); push(1, 8'h22); drive_reqs();
    repeat (3) step();
    bus_reset = 1'b1;
    step();
    step();
    bus_reset = 1'b0;
    ack_delay = 2;
    run_until_idle(30, "t5");
    expect_byte(1, 8'h22);
    check_seq("t5");

    // Line of text from one source against a single byte from another
    do_reset();
    ack_delay = 1;
    push(0, 8'h61); push(0, 8'h62); push(0, 8'h0A); push(1, 8'h58); drive_reqs();
    run_until_idle(60, "t6");
`ifdef UART_ARB_LINE_LOCK_EN
    expect_byte(0, 8'h61); expect_byte(0, 8'h62); expect_byte(0, 8'h0A); expect_byte(1, 8'h58);
`else
    expect_byte(0, 8'h61); expect_byte(1, 8'h58); expect_byte(0, 8'h62); expect_byte(0, 8'h0A);
`endif
    check_seq("t6");

    // Randomized traffic with drops, random ack latency and stray acks
    do_reset();
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) push(i, 8'h0A);
    drive_reqs();
    run_until_idle(400, "rand");
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
